// File: rtl/sdrc_init_rfsh_seq.sv
// rtl/sdrc_init_rfsh_seq.sv - SDRAM power-up init and periodic auto-refresh command sequencer
module sdrc_init_rfsh_seq #(
  parameter int INIT_WAIT = 10000,
  parameter int INIT_REFS = 2,
  parameter int TMRD      = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  cfg_sdr_cas,
  input  logic [12:0] cfg_sdr_mode_reg,
  input  logic [3:0]  cfg_sdr_trp_d,
  input  logic [3:0]  cfg_sdr_trcar_d,
  input  logic [11:0] cfg_sdr_rfsh,
  input  logic        rfsh_gnt,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        cmd_own,
  output logic        rfsh_req,
  output logic        sdr_init_done,
  output logic        rfsh_overrun
);

  // Command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Precharge-all is flagged by A10
  localparam logic [12:0] ADDR_PALL = 13'h0400;

  // Each state names the command (or NOP gap) currently on the bus
  localparam logic [3:0] S_WAIT = 4'd0;
  localparam logic [3:0] S_PRE  = 4'd1;
  localparam logic [3:0] S_TRP  = 4'd2;
  localparam logic [3:0] S_REF  = 4'd3;
  localparam logic [3:0] S_TRC  = 4'd4;
  localparam logic [3:0] S_MRS  = 4'd5;
  localparam logic [3:0] S_TMRD = 4'd6;
  localparam logic [3:0] S_IDLE = 4'd7;
  localparam logic [3:0] S_RREQ = 4'd8;
  localparam logic [3:0] S_RPRE = 4'd9;
  localparam logic [3:0] S_RTRP = 4'd10;
  localparam logic [3:0] S_RREF = 4'd11;
  localparam logic [3:0] S_RTRC = 4'd12;

  localparam int              WAIT_W     = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam logic [3:0]      REFS_LAST  = 4'(INIT_REFS);
  localparam logic [3:0]      TMRD_LAST  = 4'(TMRD - 1);

  logic [3:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        dly_cnt;
  logic [3:0]        ref_cnt;
  logic [3:0]        cmd_r;
  logic [12:0]       addr_r;
  logic [11:0]       ivl_cnt;

  logic [3:0]  trp_last;
  logic [3:0]  trc_last;
  logic [12:0] mrs_addr;
  logic        gnt_take;
  logic        ivl_load;
  logic        ivl_run;
  logic        ivl_expire;

  // A programmed delay of 0 still yields one NOP, so the gap counter starts at max(d,1)-1
  assign trp_last = (cfg_sdr_trp_d == 4'd0) ? 4'd0 : cfg_sdr_trp_d - 4'd1;
  assign trc_last = (cfg_sdr_trcar_d == 4'd0) ? 4'd0 : cfg_sdr_trcar_d - 4'd1;

  // CAS latency replaces mode-register bits [6:4]; the rest pass straight through
  assign mrs_addr = (cfg_sdr_mode_reg & 13'h1f8f) | {6'b0, cfg_sdr_cas, 4'b0};

  assign gnt_take   = (state == S_RREQ) && rfsh_gnt;
  assign ivl_load   = (state == S_TMRD) && (dly_cnt == 4'd0);
  assign ivl_run    = sdr_init_done && (cfg_sdr_rfsh != 12'd0);
  assign ivl_expire = ivl_run && (ivl_cnt == 12'd1);

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_r;
  assign sdr_addr = addr_r;
  assign sdr_ba   = 2'b00;

  // Init and refresh sequencing; command and address are registered with the state change
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= S_WAIT;
      wait_cnt      <= '0;
      dly_cnt       <= 4'd0;
      ref_cnt       <= 4'd0;
      cmd_r         <= CMD_NOP;
      addr_r        <= 13'h0;
      cmd_own       <= 1'b1;
      sdr_init_done <= 1'b0;
    end else begin
      cmd_r  <= CMD_NOP;
      addr_r <= 13'h0;
      case (state)
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= S_PRE;
            cmd_r  <= CMD_PRE;
            addr_r <= ADDR_PALL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_PRE: begin
          state   <= S_TRP;
          dly_cnt <= trp_last;
        end
        S_TRP: begin
          if (dly_cnt == 4'd0) begin
            state   <= S_REF;
            cmd_r   <= CMD_REF;
            ref_cnt <= ref_cnt + 4'd1;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        S_REF: begin
          state   <= S_TRC;
          dly_cnt <= trc_last;
        end
        S_TRC: begin
          if (dly_cnt != 4'd0) begin
            dly_cnt <= dly_cnt - 4'd1;
          end else if (ref_cnt == REFS_LAST) begin
            state  <= S_MRS;
            cmd_r  <= CMD_MRS;
            addr_r <= mrs_addr;
          end else begin
            state   <= S_REF;
            cmd_r   <= CMD_REF;
            ref_cnt <= ref_cnt + 4'd1;
          end
        end
        S_MRS: begin
          state   <= S_TMRD;
          dly_cnt <= TMRD_LAST;
        end
        S_TMRD: begin
          if (dly_cnt == 4'd0) begin
            state         <= S_IDLE;
            sdr_init_done <= 1'b1;
            cmd_own       <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        S_IDLE: begin
          if (rfsh_req) begin
            state <= S_RREQ;
          end
        end
        S_RREQ: begin
          if (rfsh_gnt) begin
            state   <= S_RPRE;
            cmd_r   <= CMD_PRE;
            addr_r  <= ADDR_PALL;
            cmd_own <= 1'b1;
          end
        end
        S_RPRE: begin
          state   <= S_RTRP;
          dly_cnt <= trp_last;
        end
        S_RTRP: begin
          if (dly_cnt == 4'd0) begin
            state <= S_RREF;
            cmd_r <= CMD_REF;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        S_RREF: begin
          state   <= S_RTRC;
          dly_cnt <= trc_last;
        end
        S_RTRC: begin
          if (dly_cnt == 4'd0) begin
            state   <= S_IDLE;
            cmd_own <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        default: begin
          state   <= S_WAIT;
          cmd_own <= 1'b1;
        end
      endcase
    end
  end

  // Free-running refresh interval; one request outstanding at most, extra expiries flag overrun
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ivl_cnt      <= 12'd0;
      rfsh_req     <= 1'b0;
      rfsh_overrun <= 1'b0;
    end else begin
      rfsh_overrun <= 1'b0;
      if (ivl_load) begin
        ivl_cnt <= cfg_sdr_rfsh;
      end else if (ivl_run) begin
        if (ivl_cnt <= 12'd1) begin
          ivl_cnt <= cfg_sdr_rfsh;
        end else begin
          ivl_cnt <= ivl_cnt - 12'd1;
        end
      end
      if (ivl_expire && rfsh_req) begin
        rfsh_overrun <= 1'b1;
      end
      if (gnt_take) begin
        rfsh_req <= 1'b0;
      end else if (ivl_expire) begin
        rfsh_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_init_rfsh_seq.sv
// tb/tb_sdrc_init_rfsh_seq.sv - scoreboard bench for sdrc_init_rfsh_seq
module tb_sdrc_init_rfsh_seq;

  localparam int INIT_WAIT = 10000;
  localparam int INIT_REFS = 2;
  localparam int TMRD      = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } cmd_ev_t;

  typedef struct {
    int cyc;
    bit val;
  } lvl_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg_cas = 3'd0;
  logic [12:0] cfg_mode = 13'h0;
  logic [3:0]  cfg_trp = 4'd0;
  logic [3:0]  cfg_trc = 4'd0;
  logic [11:0] cfg_rfsh = 12'd0;
  logic        rfsh_gnt = 1'b0;
  logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        cmd_own, rfsh_req, sdr_init_done, rfsh_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_from = 0;
  int horizon = 0;
  int done_cyc = 0;
  bit mon_en = 1'b0;
  bit own_exp = 1'b1;
  bit req_exp = 1'b0;
  bit ovr_exp = 1'b0;

  cmd_ev_t cmd_q[$];
  lvl_ev_t own_q[$];
  lvl_ev_t req_q[$];
  int      ovr_q[$];

  sdrc_init_rfsh_seq #(.INIT_WAIT(INIT_WAIT), .INIT_REFS(INIT_REFS), .TMRD(TMRD)) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .cfg_sdr_cas      (cfg_cas),
    .cfg_sdr_mode_reg (cfg_mode),
    .cfg_sdr_trp_d    (cfg_trp),
    .cfg_sdr_trcar_d  (cfg_trc),
    .cfg_sdr_rfsh     (cfg_rfsh),
    .rfsh_gnt         (rfsh_gnt),
    .sdr_cs_n         (sdr_cs_n),
    .sdr_ras_n        (sdr_ras_n),
    .sdr_cas_n        (sdr_cas_n),
    .sdr_we_n         (sdr_we_n),
    .sdr_addr         (sdr_addr),
    .sdr_ba           (sdr_ba),
    .cmd_own          (cmd_own),
    .rfsh_req         (rfsh_req),
    .sdr_init_done    (sdr_init_done),
    .rfsh_overrun     (rfsh_overrun)
  );

  always #5 clk = ~clk;

  // cycle 0 is the first cycle with reset low
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input bit ok, input int at, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, at, act, exp);
    end
  endtask

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int init_len(input int trp, input int trc);
    return INIT_WAIT + 1 + mx1(trp) + INIT_REFS * (1 + mx1(trc)) + 1 + TMRD;
  endfunction

  task automatic push_cmd(input int t, input logic [3:0] c, input logic [12:0] a, input int h);
    cmd_ev_t e;
    if (t < h) begin
      e.cyc = t; e.cmd = c; e.addr = a;
      cmd_q.push_back(e);
    end
  endtask

  task automatic push_lvl(input bit is_own, input int t, input bit v, input int h);
    lvl_ev_t e;
    if (t < h) begin
      e.cyc = t; e.val = v;
      if (is_own) own_q.push_back(e); else req_q.push_back(e);
    end
  endtask

  // Timeline model: init commands from the delay rules, then one request/service per interval
  task automatic build_model(input int trp, input int trc, input logic [2:0] cas,
                             input logic [12:0] mode, input int rr, input int g, input int h,
                             output int done_t, output int first_rref);
    int t, r, rreq, c, p, rref, fr, e;
    logic [12:0] ma;
    cmd_q.delete(); own_q.delete(); req_q.delete(); ovr_q.delete();
    t = INIT_WAIT;
    push_cmd(t, PRE, 13'h0400, h);
    t += 1 + mx1(trp);
    for (int i = 0; i < INIT_REFS; i++) begin
      push_cmd(t, REF, 13'h0, h);
      t += 1 + mx1(trc);
    end
    ma = {mode[12:7], cas, mode[3:0]};
    push_cmd(t, MRS, ma, h);
    done_t = t + 1 + TMRD;
    push_lvl(1'b1, done_t, 1'b0, h);
    first_rref = -1;
    fr = done_t;
    if (rr > 0) begin
      r = done_t + rr;
      while (r < h) begin
        push_lvl(1'b0, r, 1'b1, h);
        rreq = ((r > fr) ? r : fr) + 1;
        c = (rreq > g) ? rreq : g;
        p = c + 1;
        e = r + rr;
        while (e <= p) begin
          if (e < h) ovr_q.push_back(e);
          e += rr;
        end
        push_lvl(1'b0, p, 1'b0, h);
        push_lvl(1'b1, p, 1'b1, h);
        push_cmd(p, PRE, 13'h0400, h);
        rref = p + 1 + mx1(trp);
        push_cmd(rref, REF, 13'h0, h);
        if (first_rref < 0) first_rref = rref;
        fr = rref + 1 + mx1(trc);
        push_lvl(1'b1, fr, 1'b0, h);
        r = e;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd"}, {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} == NOP, cyc,
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, NOP);
    chk({tag, "_addr"}, sdr_addr == 13'h0 && sdr_ba == 2'b00, cyc, {sdr_ba, sdr_addr}, 0);
    chk({tag, "_own"}, cmd_own == 1'b1, cyc, cmd_own, 1);
    chk({tag, "_req"}, rfsh_req == 1'b0, cyc, rfsh_req, 0);
    chk({tag, "_done"}, sdr_init_done == 1'b0, cyc, sdr_init_done, 0);
    chk({tag, "_ovr"}, rfsh_overrun == 1'b0, cyc, rfsh_overrun, 0);
  endtask

  task automatic run_phase(input int trp, input int trc, input logic [2:0] cas, input logic [12:0] mode,
                           input int rr, input int g_rel, input int span, input bit abort);
    int dt, fref, h;
    rst = 1'b1;
    @(posedge clk); #1;
    cfg_trp = 4'(trp); cfg_trc = 4'(trc); cfg_cas = cas; cfg_mode = mode; cfg_rfsh = 12'(rr);
    @(negedge clk);
    check_reset_vals("reset");
    dt = init_len(trp, trc);
    gnt_from = dt + g_rel;
    h = dt + span;
    build_model(trp, trc, cas, mode, rr, gnt_from, h, dt, fref);
    if (abort) begin
      h = fref + 2;
      build_model(trp, trc, cas, mode, rr, gnt_from, h, dt, fref);
    end
    done_cyc = dt;
    horizon = h;
    own_exp = 1'b1;
    req_exp = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    if (!abort) begin
      while (cyc < h) begin @(posedge clk); #1; end
      mon_en = 1'b0;
    end else begin
      while (cyc < h - 1) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b0;
      @(negedge clk);
      check_reset_vals("abort");
    end
    chk("leftover_cmd", cmd_q.size() == 0, cyc, cmd_q.size(), 0);
    chk("leftover_lvl", own_q.size() + req_q.size() + ovr_q.size() == 0, cyc,
        own_q.size() + req_q.size() + ovr_q.size(), 0);
  endtask

  // Grant follows a per-phase step: low before gnt_from, high from then on
  initial begin
    forever begin
      @(posedge clk); #1;
      rfsh_gnt = (cyc >= gnt_from);
    end
  end

  // Monitor: every cycle compares the bus against the scoreboard queues
  logic [3:0] cur;
  cmd_ev_t    ce;
  lvl_ev_t    le;
  always @(negedge clk) begin
    if (mon_en && cyc < horizon) begin
      cur = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        ce = cmd_q.pop_front();
        chk("cmd_code", cur == ce.cmd, cyc, cur, ce.cmd);
        chk("cmd_addr", sdr_addr == ce.addr, cyc, sdr_addr, ce.addr);
      end else begin
        chk("nop", cur == NOP && sdr_addr == 13'h0, cyc, {cur, sdr_addr}, {NOP, 13'h0});
      end
      chk("ba", sdr_ba == 2'b00, cyc, sdr_ba, 0);
      if (own_q.size() > 0 && own_q[0].cyc == cyc) begin
        le = own_q.pop_front();
        own_exp = le.val;
      end
      chk("cmd_own", cmd_own == own_exp, cyc, cmd_own, own_exp);
      if (req_q.size() > 0 && req_q[0].cyc == cyc) begin
        le = req_q.pop_front();
        req_exp = le.val;
      end
      chk("rfsh_req", rfsh_req == req_exp, cyc, rfsh_req, req_exp);
      ovr_exp = 1'b0;
      if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
        void'(ovr_q.pop_front());
        ovr_exp = 1'b1;
      end
      chk("overrun", rfsh_overrun == ovr_exp, cyc, rfsh_overrun, ovr_exp);
      chk("init_done", sdr_init_done == (cyc >= done_cyc), cyc, sdr_init_done, (cyc >= done_cyc));
    end
  end

  initial begin
    // nominal timing, CAS 3 MRS, 100-cycle refresh with grant always high
    run_phase(2, 4, 3'd3, 13'h0007, 100, -20000, 450, 1'b0);
    // grant withheld 120 cycles after the first request at a 50-cycle interval
    run_phase($urandom_range(0, 15), $urandom_range(0, 15), 3'($urandom_range(1, 7)),
              13'($urandom), 50, 50 + 120, 400, 1'b0);
    // zero delays still leave one NOP; refresh disabled
    run_phase(0, 0, 3'($urandom_range(1, 7)), 13'($urandom), 0, 0, 5000, 1'b0);
    // reset in the middle of a refresh recovery gap
    run_phase($urandom_range(0, 15), $urandom_range(0, 15), 3'($urandom_range(1, 7)),
              13'($urandom), $urandom_range(20, 60), 0, 1000, 1'b1);
    // random configurations and grant latency
    for (int k = 0; k < 2; k++) begin
      run_phase($urandom_range(0, 15), $urandom_range(0, 15), 3'($urandom_range(1, 7)),
                13'($urandom), $urandom_range(10, 150), $urandom_range(0, 400), 800, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
